mult_err_monitor: RTL and testbench

MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

---
 rtl/mult_err_pkg.sv | 21 ++
 rtl/mult_err_monitor_ed_calc.sv | 21 ++
 rtl/mult_err_monitor.sv | 167 ++++++++++++++++
 tb/tb_mult_err_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_err_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
// Frame length bounds and accumulator widths are sized so no accumulator can wrap.
package mult_err_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned OP_W          = 4;
   localparam int unsigned PROD_W        = 8;
   localparam int unsigned DIFF_W        = 9;
   localparam int unsigned ED_W          = 8;
   localparam int unsigned SUM_W         = 16;
   localparam int unsigned SERR_W        = 17;
   localparam int unsigned CNT_W         = 9;
   localparam int unsigned FRAME_LEN_DEF = 256;

endpackage

// File: rtl/mult_err_monitor_ed_calc.sv
// Combinational error calculator: exact product, signed difference and absolute error
// of one approximate product against the true 4x4 product.
module ed_calc
   import mult_err_pkg::*;
(
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   input  logic [PROD_W-1:0] p_i,
   output logic [PROD_W-1:0] exact_o,
   output logic [DIFF_W-1:0] diff_o,
   output logic [ED_W-1:0]   ed_o
);

   always_comb begin
      exact_o = {{(PROD_W-OP_W){1'b0}}, a_i} * {{(PROD_W-OP_W){1'b0}}, b_i};
      diff_o  = {1'b0, p_i} - {1'b0, exact_o};
      // |diff| never exceeds 255, so the low byte of the negation is exact
      ed_o    = diff_o[DIFF_W-1] ? (~diff_o[ED_W-1:0] + 8'd1) : diff_o[ED_W-1:0];
   end

endmodule

// File: rtl/mult_err_monitor.sv
// Frame-based error monitor for an approximate 4x4 multiplier: accepts FRAME_LEN samples,
// accumulates error count, sum of |error|, signed error sum and peak |error| over a 2-stage pipe.
module mult_err_monitor
   import mult_err_pkg::*;
#(
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   input  logic [PROD_W-1:0] in_p,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  err_count,
   output logic [SUM_W-1:0]  sum_ed,
   output logic [SERR_W-1:0] sum_err,
   output logic [ED_W-1:0]   max_ed
);

   state_e              state_q, state_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                s1_valid_q;
   logic [PROD_W-1:0]   s1_exact_q;
   logic [PROD_W-1:0]   s1_p_q;
   logic [DIFF_W-1:0]   s1_diff_q;
   logic [ED_W-1:0]     s1_ed_q;

   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic [SUM_W-1:0]    sum_ed_q, sum_ed_d;
   logic [SERR_W-1:0]   sum_err_q, sum_err_d;
   logic [ED_W-1:0]     max_ed_q, max_ed_d;

   logic [PROD_W-1:0]   calc_exact;
   logic [DIFF_W-1:0]   calc_diff;
   logic [ED_W-1:0]     calc_ed;

   logic                accept;
   logic                last_accept;
   logic                enter_run;

   ed_calc u_ed_calc (
      .a_i     (in_a),
      .b_i     (in_b),
      .p_i     (in_p),
      .exact_o (calc_exact),
      .diff_o  (calc_diff),
      .ed_o    (calc_ed)
   );

   assign accept      = in_valid && (state_q == ST_RUN);
   assign last_accept = accept && (cnt_q == CNT_W'(FRAME_LEN - 1));
   assign enter_run   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (last_accept) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // stage 2 has consumed the final sample once stage 1 is empty
            if (!s1_valid_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            if (start) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (enter_run) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_exact_q <= '0;
         s1_p_q     <= '0;
         s1_diff_q  <= '0;
         s1_ed_q    <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_exact_q <= calc_exact;
            s1_p_q     <= in_p;
            s1_diff_q  <= calc_diff;
            s1_ed_q    <= calc_ed;
         end
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      sum_ed_d  = sum_ed_q;
      sum_err_d = sum_err_q;
      max_ed_d  = max_ed_q;
      if (enter_run) begin
         err_cnt_d = '0;
         sum_ed_d  = '0;
         sum_err_d = '0;
         max_ed_d  = '0;
      end else if (s1_valid_q) begin
         if (s1_p_q != s1_exact_q) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
         sum_ed_d  = sum_ed_q + {{(SUM_W-ED_W){1'b0}}, s1_ed_q};
         sum_err_d = sum_err_q + {{(SERR_W-DIFF_W){s1_diff_q[DIFF_W-1]}}, s1_diff_q};
         if (s1_ed_q > max_ed_q) begin
            max_ed_d = s1_ed_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
         sum_ed_q  <= '0;
         sum_err_q <= '0;
         max_ed_q  <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         sum_ed_q  <= sum_ed_d;
         sum_err_q <= sum_err_d;
         max_ed_q  <= max_ed_d;
      end
   end

   assign in_ready  = (state_q == ST_RUN);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = done_q;
   assign err_count = err_cnt_q;
   assign sum_ed    = sum_ed_q;
   assign sum_err   = sum_err_q;
   assign max_ed    = max_ed_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Directed bench for mult_err_monitor: three instances (FRAME_LEN 256, 3, 4) with a
// table of 3-sample frames plus hand-written multi-cycle sequences.
module tb_mult_err_monitor;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0] a, b;
   logic [7:0] p;

   logic start_f, valid_f, rdy_f, busy_f, done_f;
   logic [8:0] errc_f;
   logic [15:0] sed_f;
   logic [16:0] serr_f;
   logic [7:0] max_f;

   logic start_s, valid_s, rdy_s, busy_s, done_s;
   logic [8:0] errc_s;
   logic [15:0] sed_s;
   logic [16:0] serr_s;
   logic [7:0] max_s;

   logic start_q, valid_q, rdy_q, busy_q, done_q;
   logic [8:0] errc_q;
   logic [15:0] sed_q;
   logic [16:0] serr_q;
   logic [7:0] max_q;

   mult_err_monitor #(.FRAME_LEN(256)) u_f (
      .clk(clk), .rst_n(rst_n), .start(start_f), .in_valid(valid_f), .in_ready(rdy_f),
      .in_a(a), .in_b(b), .in_p(p), .busy(busy_f), .done(done_f),
      .err_count(errc_f), .sum_ed(sed_f), .sum_err(serr_f), .max_ed(max_f)
   );

   mult_err_monitor #(.FRAME_LEN(3)) u_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(valid_s), .in_ready(rdy_s),
      .in_a(a), .in_b(b), .in_p(p), .busy(busy_s), .done(done_s),
      .err_count(errc_s), .sum_ed(sed_s), .sum_err(serr_s), .max_ed(max_s)
   );

   mult_err_monitor #(.FRAME_LEN(4)) u_q (
      .clk(clk), .rst_n(rst_n), .start(start_q), .in_valid(valid_q), .in_ready(rdy_q),
      .in_a(a), .in_b(b), .in_p(p), .busy(busy_q), .done(done_q),
      .err_count(errc_q), .sum_ed(sed_q), .sum_err(serr_q), .max_ed(max_q)
   );

   typedef struct packed {
      logic [2:0][3:0] a;
      logic [2:0][3:0] b;
      logic [2:0][7:0] p;
      int errc;
      int sed;
      int serr;
      int mx;
   } vec_t;

   vec_t tbl[5];
   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input int a0, b0, p0, a1, b1, p1, a2, b2, p2,
                               input int e, s, se, m);
      vec_t v;
      v.a[0] = 4'(a0); v.b[0] = 4'(b0); v.p[0] = 8'(p0);
      v.a[1] = 4'(a1); v.b[1] = 4'(b1); v.p[1] = 8'(p1);
      v.a[2] = 4'(a2); v.b[2] = 4'(b2); v.p[2] = 8'(p2);
      v.errc = e; v.sed = s; v.serr = se; v.mx = m;
      return v;
   endfunction

   // Lower-part-OR style approximation: exact upper bits, OR of operand low bits below
   function automatic logic [7:0] approx_mul(input logic [3:0] x, input logic [3:0] y);
      logic [7:0] e;
      e = {4'b0, x} * {4'b0, y};
      return {e[7:3], x[2:0] | y[2:0]};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int saw;
      int m_err, m_sed, m_serr, m_max;
      logic [6:0] pat;

      tbl[0] = mk(3, 5, 17,   0, 0, 255,  15, 15, 200,  3, 282, 232, 255);
      tbl[1] = mk(1, 1, 1,    7, 8, 56,   15, 15, 225,  0, 0, 0, 0);
      tbl[2] = mk(15, 15, 0,  15, 15, 0,  15, 15, 0,    3, 675, -675, 225);
      tbl[3] = mk(2, 3, 7,    2, 3, 5,    0, 5, 4,      3, 6, 4, 4);
      tbl[4] = mk(4, 4, 16,   4, 4, 20,   1, 0, 0,      1, 4, 4, 4);

      a = '0; b = '0; p = '0;
      start_f = 0; valid_f = 0; start_s = 0; valid_s = 0; start_q = 0; valid_q = 0;
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_in_ready", rdy_f, 0);
      check("rst_busy", busy_f, 0);
      check("rst_done", done_f, 0);
      check("rst_err_count", errc_f, 0);
      check("rst_sum_ed", sed_f, 0);
      check("rst_sum_err", serr_f, 0);
      check("rst_max_ed", max_f, 0);
      rst_n = 1'b1;
      tick();

      // Exhaustive exact-product frame
      start_f = 1; tick(); start_f = 0;
      check("f256_ready_after_start", rdy_f, 1);
      valid_f = 1;
      for (int i = 0; i < 256; i++) begin
         a = 4'(i >> 4); b = 4'(i & 15); p = 8'(i >> 4) * 8'(i & 15);
         tick();
      end
      valid_f = 0;
      n = 256;
      while (!done_f && n < 300) begin tick(); n++; end
      check("f256_done_latency", n, 258);
      check("f256_err_count", errc_f, 0);
      check("f256_sum_ed", sed_f, 0);
      check("f256_sum_err", $signed(serr_f), 0);
      check("f256_max_ed", max_f, 0);
      tick();
      check("f256_done_one_cycle", done_f, 0);
      check("f256_idle_after_done", busy_f, 0);

      // Table of FRAME_LEN=3 frames
      for (int r = 0; r < 5; r++) begin
         start_s = 1; tick(); start_s = 0;
         check($sformatf("tbl%0d_cleared", r), errc_s, 0);
         valid_s = 1;
         for (int k = 0; k < 3; k++) begin
            a = tbl[r].a[k]; b = tbl[r].b[k]; p = tbl[r].p[k];
            tick();
         end
         valid_s = 0;
         n = 0;
         while (!done_s && n < 10) begin tick(); n++; end
         check($sformatf("tbl%0d_done_wait", r), n, 2);
         check($sformatf("tbl%0d_err_count", r), errc_s, tbl[r].errc);
         check($sformatf("tbl%0d_sum_ed", r), sed_s, tbl[r].sed);
         check($sformatf("tbl%0d_sum_err", r), $signed(serr_s), tbl[r].serr);
         check($sformatf("tbl%0d_max_ed", r), max_s, tbl[r].mx);
      end

      // Gapped valid on FRAME_LEN=4
      start_q = 1; tick(); start_q = 0;
      a = 4'd2; b = 4'd2; p = 8'd5;
      pat = 7'b1011001;
      for (int k = 0; k < 7; k++) begin
         valid_q = pat[k];
         if (k == 1) check("gap_no_early_update", errc_q, 0);
         if (k == 2) check("gap_update_latency", errc_q, 1);
         if (k == 5) check("gap_mid_count", errc_q, 2);
         tick();
      end
      valid_q = 0;
      check("gap_drain1_busy", busy_q, 1);
      check("gap_drain1_done", done_q, 0);
      tick();
      check("gap_drain2_ready", rdy_q, 0);
      check("gap_drain2_done", done_q, 0);
      tick();
      check("gap_done", done_q, 1);
      check("gap_err_count", errc_q, 4);
      check("gap_sum_ed", sed_q, 4);
      check("gap_sum_err", $signed(serr_q), 4);
      check("gap_max_ed", max_q, 1);
      tick();
      check("gap_hold_in_done", errc_q, 4);

      // Start in DONE clears; start in RUN is ignored
      start_q = 1; tick(); start_q = 0;
      check("restart_err_count", errc_q, 0);
      check("restart_sum_ed", sed_q, 0);
      check("restart_max_ed", max_q, 0);
      check("restart_ready", rdy_q, 1);
      a = 4'd3; b = 4'd3; p = 8'd6;
      valid_q = 1; tick(); tick(); valid_q = 0;
      tick(); tick();
      start_q = 1; tick(); start_q = 0;
      check("run_start_no_clear", errc_q, 2);
      check("run_start_still_ready", rdy_q, 1);
      valid_q = 1; tick(); tick(); valid_q = 0;
      n = 0;
      while (!done_q && n < 10) begin tick(); n++; end
      check("run_start_done_wait", n, 2);
      check("run_start_err_count", errc_q, 4);
      check("run_start_sum_err", $signed(serr_q), -12);
      check("run_start_sum_ed", sed_q, 12);

      // Reset in the middle of a frame
      start_f = 1; tick(); start_f = 0;
      a = 4'd1; b = 4'd1; p = 8'd2;
      valid_f = 1;
      repeat (10) tick();
      valid_f = 0;
      tick(); tick();
      check("midrst_before", errc_f, 10);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_err_count", errc_f, 0);
      check("midrst_sum_ed", sed_f, 0);
      check("midrst_max_ed", max_f, 0);
      check("midrst_ready", rdy_f, 0);
      check("midrst_busy", busy_f, 0);
      tick();
      rst_n = 1'b1;
      valid_f = 1;
      saw = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done_f || rdy_f) saw = 1;
      end
      valid_f = 0;
      check("midrst_no_done_or_ready", saw, 0);

      // start honoured on the first edge after release, then an approximate frame
      rst_n = 1'b0;
      tick();
      start_f = 1;
      rst_n = 1'b1;
      tick();
      start_f = 0;
      check("start_first_edge", rdy_f, 1);
      m_err = 0; m_sed = 0; m_serr = 0; m_max = 0;
      for (int i = 0; i < 256; i++) begin
         int ex, pv, d, ad;
         if (i % 37 == 5) begin
            valid_f = 0;
            tick();
         end
         a = 4'(i >> 4); b = 4'(i & 15); p = approx_mul(a, b);
         ex = (i >> 4) * (i & 15);
         pv = int'(p);
         d = pv - ex;
         ad = (d < 0) ? -d : d;
         if (d != 0) m_err++;
         m_sed += ad;
         m_serr += d;
         if (ad > m_max) m_max = ad;
         valid_f = 1;
         tick();
      end
      valid_f = 0;
      n = 0;
      while (!done_f && n < 10) begin tick(); n++; end
      check("approx_done_wait", n, 2);
      check("approx_err_count", errc_f, m_err);
      check("approx_sum_ed", sed_f, m_sed);
      check("approx_sum_err", $signed(serr_f), m_serr);
      check("approx_max_ed", max_f, m_max);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
